// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I controller.
// Opcodes, datapath select codes, ALU op classes and FSM states.
package multi_cycle_controller_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMMEXT    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_BRANCH,
        ALUOP_R,
        ALUOP_I
    } aluop_e;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_JAL,
        S_JALR1,
        S_JALR2,
        S_BRANCH,
        S_LUI
    } state_e;

endpackage

// File: rtl/multi_cycle_controller_alu_decoder.sv
// ALU control decode from op class, func3 and func7[5].
// Unrecognised combinations fall back to ADD.
module alu_decoder
    import multi_cycle_controller_pkg::*;
(
    input  aluop_e     i_alu_op,
    input  logic [2:0] i_func3,
    input  logic       i_func7_5,
    output logic [2:0] o_alu_control
);

    // Pick the ALU operation for the current op class
    always_comb begin
        o_alu_control = ALU_ADD;
        unique case (i_alu_op)
            ALUOP_ADD: o_alu_control = ALU_ADD;
            ALUOP_BRANCH: begin
                case (i_func3)
                    3'b000, 3'b001: o_alu_control = ALU_SUB;
                    3'b100, 3'b101: o_alu_control = ALU_SLT;
                    default:        o_alu_control = ALU_ADD;
                endcase
            end
            ALUOP_R: begin
                case (i_func3)
                    3'b000:  o_alu_control = i_func7_5 ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b011:  o_alu_control = ALU_SLTU;
                    3'b100:  o_alu_control = ALU_XOR;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            ALUOP_I: begin
                // Immediate forms never subtract; func7 is ignored here
                case (i_func3)
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b011:  o_alu_control = ALU_SLTU;
                    3'b100:  o_alu_control = ALU_XOR;
                    3'b110:  o_alu_control = ALU_OR;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// Control FSM for the multi-cycle RV32I core.
// Moore outputs from state/IR fields; branch PCWrite also uses zero/LSB.
module multi_cycle_controller
    import multi_cycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       zero,
    input  logic       LSB,
    output logic       PCWrite,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       IRWrite,
    output logic       regWrite,
    output logic [2:0] ALUControl,
    output logic [2:0] immSrc,
    output logic [1:0] resultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       illegal_op
);

    state_e     r_state;
    state_e     w_next_state;
    aluop_e     w_alu_op;
    logic [2:0] w_alu_control;
    logic       w_unused;

    assign w_unused = &{1'b0, func7[6], func7[4:0]};

    // Op class handed to the ALU decoder depends only on the state
    always_comb begin
        w_alu_op = ALUOP_ADD;
        case (r_state)
            S_EXEC_R: w_alu_op = ALUOP_R;
            S_EXEC_I: w_alu_op = ALUOP_I;
            S_BRANCH: w_alu_op = ALUOP_BRANCH;
            default:  w_alu_op = ALUOP_ADD;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_func3       (func3),
        .i_func7_5     (func7[5]),
        .o_alu_control (w_alu_control)
    );

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next_state;
    end

    // Next-state and datapath controls
    always_comb begin
        w_next_state = S_FETCH;
        PCWrite      = 1'b0;
        adrSrc       = 1'b0;
        memWrite     = 1'b0;
        IRWrite      = 1'b0;
        regWrite     = 1'b0;
        ALUControl   = w_alu_control;
        immSrc       = IMM_I;
        resultSrc    = RES_ALUOUT;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_B;
        illegal_op   = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                IRWrite      = 1'b1;
                PCWrite      = 1'b1;
                ALUSrcB      = SRCB_FOUR;
                resultSrc    = RES_ALURESULT;
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                // Precompute oldPC+imm so branches/jal find the target in ALUOut
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                immSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
                case (op)
                    OP_LOAD,
                    OP_STORE:  w_next_state = S_MEMADR;
                    OP_R:      w_next_state = S_EXEC_R;
                    OP_I:      w_next_state = S_EXEC_I;
                    OP_JAL:    w_next_state = S_JAL;
                    OP_JALR:   w_next_state = S_JALR1;
                    OP_BRANCH: w_next_state = S_BRANCH;
                    OP_LUI:    w_next_state = S_LUI;
                    default: begin
                        illegal_op   = 1'b1;
                        w_next_state = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA      = SRCA_A;
                ALUSrcB      = SRCB_IMM;
                immSrc       = (op == OP_STORE) ? IMM_S : IMM_I;
                w_next_state = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adrSrc       = 1'b1;
                w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                resultSrc    = RES_DATA;
                regWrite     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                adrSrc       = 1'b1;
                memWrite     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_EXEC_R: begin
                ALUSrcA      = SRCA_A;
                w_next_state = S_ALUWB;
            end
            S_EXEC_I: begin
                ALUSrcA      = SRCA_A;
                ALUSrcB      = SRCB_IMM;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                regWrite     = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JAL, S_JALR2: begin
                // Jump to ALUOut while the ALU forms the link address
                PCWrite      = 1'b1;
                ALUSrcA      = SRCA_OLDPC;
                ALUSrcB      = SRCB_FOUR;
                w_next_state = S_ALUWB;
            end
            S_JALR1: begin
                ALUSrcA      = SRCA_A;
                ALUSrcB      = SRCB_IMM;
                w_next_state = S_JALR2;
            end
            S_BRANCH: begin
                ALUSrcA = SRCA_A;
                case (func3)
                    3'b000:  PCWrite = zero;
                    3'b001:  PCWrite = ~zero;
                    3'b100:  PCWrite = LSB;
                    3'b101:  PCWrite = ~LSB;
                    default: PCWrite = 1'b0;
                endcase
                w_next_state = S_FETCH;
            end
            S_LUI: begin
                immSrc       = IMM_U;
                resultSrc    = RES_IMMEXT;
                regWrite     = 1'b1;
                w_next_state = S_FETCH;
            end
            default: w_next_state = S_FETCH;
        endcase
        if (rst) begin
            PCWrite    = 1'b0;
            adrSrc     = 1'b0;
            memWrite   = 1'b0;
            IRWrite    = 1'b0;
            regWrite   = 1'b0;
            ALUControl = 3'b000;
            immSrc     = 3'b000;
            resultSrc  = 2'b00;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b00;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Self-checking bench for multi_cycle_controller.
// Per-cycle expected control words are queued per instruction and popped each cycle.
module tb_multi_cycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] func3 = '0;
    logic [6:0] func7 = '0;
    logic       zero = 1'b0;
    logic       LSB = 1'b0;
    logic       PCWrite, adrSrc, memWrite, IRWrite, regWrite, illegal_op;
    logic [2:0] ALUControl, immSrc;
    logic [1:0] resultSrc, ALUSrcA, ALUSrcB;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        z;
        logic        l;
        logic [17:0] exp;
    } ent_t;

    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [17:0] outs;
    assign outs = {PCWrite, adrSrc, memWrite, IRWrite, regWrite, ALUControl,
                   immSrc, resultSrc, ALUSrcA, ALUSrcB, illegal_op};

    always #5 clk = ~clk;

    multi_cycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
        .zero(zero), .LSB(LSB), .PCWrite(PCWrite), .adrSrc(adrSrc),
        .memWrite(memWrite), .IRWrite(IRWrite), .regWrite(regWrite),
        .ALUControl(ALUControl), .immSrc(immSrc), .resultSrc(resultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .illegal_op(illegal_op)
    );

    function automatic logic [17:0] mk(
        input logic pcw, input logic adr, input logic mw, input logic irw,
        input logic rw, input logic [2:0] alu, input logic [2:0] imm,
        input logic [1:0] res, input logic [1:0] sa, input logic [1:0] sbs,
        input logic ill);
        return {pcw, adr, mw, irw, rw, alu, imm, res, sa, sbs, ill};
    endfunction

    function automatic logic [2:0] alu_r(input logic [2:0] f3, input logic b5);
        case (f3)
            3'd0: return b5 ? 3'b001 : 3'b000;
            3'd2: return 3'b101;
            3'd3: return 3'b110;
            3'd4: return 3'b100;
            3'd6: return 3'b011;
            3'd7: return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] alu_i(input logic [2:0] f3);
        case (f3)
            3'd2: return 3'b101;
            3'd3: return 3'b110;
            3'd4: return 3'b100;
            3'd6: return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    // Push the full per-cycle expectation of one instruction
    task automatic push_instr(input logic [6:0] o, input logic [2:0] f3,
                              input logic [6:0] f7, input logic z, input logic l);
        ent_t e;
        logic [17:0] wb;
        logic [2:0] bal;
        logic bpc;
        e.op = o; e.f3 = f3; e.f7 = f7; e.z = z; e.l = l;
        wb = mk(0,0,0,0,1,3'd0,3'd0,2'd0,2'd0,2'd0,0);
        e.exp = mk(1,0,0,1,0,3'd0,3'd0,2'd2,2'd0,2'd2,0);
        sb.push_back(e);
        e.exp = mk(0,0,0,0,0,3'd0,(o == 7'b1101111) ? 3'd3 : 3'd2,2'd0,2'd1,2'd1,0);
        case (o)
            7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1101111, 7'b1100111, 7'b1100011, 7'b0110111: sb.push_back(e);
            default: begin
                e.exp[0] = 1'b1;
                sb.push_back(e);
            end
        endcase
        case (o)
            7'b0000011: begin
                e.exp = mk(0,0,0,0,0,3'd0,3'd0,2'd0,2'd2,2'd1,0); sb.push_back(e);
                e.exp = mk(0,1,0,0,0,3'd0,3'd0,2'd0,2'd0,2'd0,0); sb.push_back(e);
                e.exp = mk(0,0,0,0,1,3'd0,3'd0,2'd1,2'd0,2'd0,0); sb.push_back(e);
            end
            7'b0100011: begin
                e.exp = mk(0,0,0,0,0,3'd0,3'd1,2'd0,2'd2,2'd1,0); sb.push_back(e);
                e.exp = mk(0,1,1,0,0,3'd0,3'd0,2'd0,2'd0,2'd0,0); sb.push_back(e);
            end
            7'b0110011: begin
                e.exp = mk(0,0,0,0,0,alu_r(f3, f7[5]),3'd0,2'd0,2'd2,2'd0,0);
                sb.push_back(e);
                e.exp = wb; sb.push_back(e);
            end
            7'b0010011: begin
                e.exp = mk(0,0,0,0,0,alu_i(f3),3'd0,2'd0,2'd2,2'd1,0);
                sb.push_back(e);
                e.exp = wb; sb.push_back(e);
            end
            7'b1101111: begin
                e.exp = mk(1,0,0,0,0,3'd0,3'd0,2'd0,2'd1,2'd2,0); sb.push_back(e);
                e.exp = wb; sb.push_back(e);
            end
            7'b1100111: begin
                e.exp = mk(0,0,0,0,0,3'd0,3'd0,2'd0,2'd2,2'd1,0); sb.push_back(e);
                e.exp = mk(1,0,0,0,0,3'd0,3'd0,2'd0,2'd1,2'd2,0); sb.push_back(e);
                e.exp = wb; sb.push_back(e);
            end
            7'b1100011: begin
                case (f3)
                    3'd0: begin bal = 3'b001; bpc = z;  end
                    3'd1: begin bal = 3'b001; bpc = !z; end
                    3'd4: begin bal = 3'b101; bpc = l;  end
                    3'd5: begin bal = 3'b101; bpc = !l; end
                    default: begin bal = 3'b000; bpc = 1'b0; end
                endcase
                e.exp = mk(bpc,0,0,0,0,bal,3'd0,2'd0,2'd2,2'd0,0); sb.push_back(e);
            end
            7'b0110111: begin
                e.exp = mk(0,0,0,0,1,3'd0,3'd4,2'd3,2'd0,2'd0,0); sb.push_back(e);
            end
            default: ;
        endcase
    endtask

    task automatic test_reset();
        int k = 0;
        rst = 1'b1;
        op = 7'b0110111; func3 = 3'd5; zero = 1'b1; LSB = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (outs !== 18'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", outs, 18'h0);
        end
        rst = 1'b0;
        push_instr(7'b0110111, 3'd0, 7'd0, 1'b0, 1'b0);
        while (sb.size() != 0) begin
            ent_t e = sb.pop_front();
            op = e.op; func3 = e.f3; func7 = e.f7; zero = e.z; LSB = e.l;
            #1;
            checks++;
            if (outs !== e.exp) begin
                errors++;
                $display("FAIL reset_then_lui cyc%0d: got %h expected %h", k, outs, e.exp);
            end
            k++;
            @(negedge clk);
        end
    endtask

    task automatic test_lw_sw();
        int k = 0;
        push_instr(7'b0000011, 3'd2, 7'd0, 1'b0, 1'b0);
        push_instr(7'b0100011, 3'd2, 7'd0, 1'b1, 1'b0);
        while (sb.size() != 0) begin
            ent_t e = sb.pop_front();
            op = e.op; func3 = e.f3; func7 = e.f7; zero = e.z; LSB = e.l;
            #1;
            checks++;
            if (outs !== e.exp) begin
                errors++;
                $display("FAIL lw_sw cyc%0d: got %h expected %h", k, outs, e.exp);
            end
            k++;
            @(negedge clk);
        end
    endtask

    task automatic test_alu_ops();
        int k = 0;
        for (int f = 0; f < 8; f++) begin
            push_instr(7'b0110011, 3'(f), 7'b0100000, 1'b0, 1'b0);
            push_instr(7'b0110011, 3'(f), 7'b0000000, 1'b0, 1'b0);
            push_instr(7'b0010011, 3'(f), 7'b0100000, 1'b0, 1'b0);
        end
        while (sb.size() != 0) begin
            ent_t e = sb.pop_front();
            op = e.op; func3 = e.f3; func7 = e.f7; zero = e.z; LSB = e.l;
            #1;
            checks++;
            if (outs !== e.exp) begin
                errors++;
                $display("FAIL alu_ops cyc%0d op=%b f3=%0d: got %h expected %h",
                         k, e.op, e.f3, outs, e.exp);
            end
            k++;
            @(negedge clk);
        end
    endtask

    task automatic test_branches();
        int k = 0;
        for (int f = 0; f < 8; f++) begin
            for (int zl = 0; zl < 4; zl++) begin
                push_instr(7'b1100011, 3'(f), 7'd0, zl[0], zl[1]);
            end
        end
        while (sb.size() != 0) begin
            ent_t e = sb.pop_front();
            op = e.op; func3 = e.f3; func7 = e.f7; zero = e.z; LSB = e.l;
            #1;
            checks++;
            if (outs !== e.exp) begin
                errors++;
                $display("FAIL branch cyc%0d f3=%0d z=%b lsb=%b: got %h expected %h",
                         k, e.f3, e.z, e.l, outs, e.exp);
            end
            k++;
            @(negedge clk);
        end
    endtask

    task automatic test_jumps_lui_illegal();
        int k = 0;
        push_instr(7'b1101111, 3'd0, 7'd0, 1'b0, 1'b0);
        push_instr(7'b1100111, 3'd0, 7'd0, 1'b1, 1'b1);
        push_instr(7'b1111111, 3'd0, 7'd0, 1'b0, 1'b0);
        push_instr(7'b0110111, 3'd3, 7'd0, 1'b0, 1'b0);
        push_instr(7'b0000000, 3'd0, 7'd0, 1'b0, 1'b0);
        while (sb.size() != 0) begin
            ent_t e = sb.pop_front();
            op = e.op; func3 = e.f3; func7 = e.f7; zero = e.z; LSB = e.l;
            #1;
            checks++;
            if (outs !== e.exp) begin
                errors++;
                $display("FAIL jump_lui_illegal cyc%0d op=%b: got %h expected %h",
                         k, e.op, outs, e.exp);
            end
            k++;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [10];
        int k = 0;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b1111111, 7'b0001111};
        for (int n = 0; n < 60; n++) begin
            push_instr(ops[$urandom_range(9)], 3'($urandom_range(7)),
                       7'($urandom), 1'($urandom), 1'($urandom));
        end
        while (sb.size() != 0) begin
            ent_t e = sb.pop_front();
            op = e.op; func3 = e.f3; func7 = e.f7; zero = e.z; LSB = e.l;
            #1;
            checks++;
            if (outs !== e.exp) begin
                errors++;
                $display("FAIL back_to_back cyc%0d op=%b f3=%0d: got %h expected %h",
                         k, e.op, e.f3, outs, e.exp);
            end
            k++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midway();
        int k = 0;
        push_instr(7'b0000011, 3'd2, 7'd0, 1'b0, 1'b0);
        while (sb.size() > 1) begin
            ent_t e = sb.pop_front();
            op = e.op; func3 = e.f3; func7 = e.f7; zero = e.z; LSB = e.l;
            #1;
            checks++;
            if (outs !== e.exp) begin
                errors++;
                $display("FAIL reset_mid_lw cyc%0d: got %h expected %h", k, outs, e.exp);
            end
            k++;
            if (sb.size() > 1) @(negedge clk);
        end
        sb.delete();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (outs !== 18'h0) begin
                errors++;
                $display("FAIL reset_mid_held%0d: got %h expected %h", c, outs, 18'h0);
            end
            @(negedge clk);
        end
        rst = 1'b0;
        push_instr(7'b0110011, 3'd0, 7'b0100000, 1'b0, 1'b0);
        while (sb.size() != 0) begin
            ent_t e = sb.pop_front();
            op = e.op; func3 = e.f3; func7 = e.f7; zero = e.z; LSB = e.l;
            #1;
            checks++;
            if (outs !== e.exp) begin
                errors++;
                $display("FAIL reset_mid_resume cyc%0d: got %h expected %h", k, outs, e.exp);
            end
            k++;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_lw_sw();
        test_alu_ops();
        test_branches();
        test_jumps_lui_illegal();
        test_back_to_back();
        test_reset_midway();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
